// File: rtl/lc3b_control_pkg.sv
// Shared LC-3b types: opcodes, ALU operations, control FSM states and the control word.
// Used by lc3b_control and its optional memory-wait timer.
package lc3b_types;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef enum logic [2:0] {
        alu_add  = 3'd0,
        alu_and  = 3'd1,
        alu_not  = 3'd2,
        alu_pass = 3'd3,
        alu_sll  = 3'd4,
        alu_srl  = 3'd5,
        alu_sra  = 3'd6
    } lc3b_aluop;

    typedef enum logic [3:0] {
        s_fetch1    = 4'd0,
        s_fetch2    = 4'd1,
        s_fetch3    = 4'd2,
        s_decode    = 4'd3,
        s_add       = 4'd4,
        s_and       = 4'd5,
        s_not       = 4'd6,
        s_br        = 4'd7,
        s_br_taken  = 4'd8,
        s_calc_addr = 4'd9,
        s_ldr1      = 4'd10,
        s_ldr2      = 4'd11,
        s_str1      = 4'd12,
        s_str2      = 4'd13
    } lc3b_ctrl_state;

    typedef struct packed {
        logic      load_pc;
        logic      load_ir;
        logic      load_regfile;
        logic      load_mar;
        logic      load_mdr;
        logic      load_cc;
        logic      pcmux_sel;
        logic      storemux_sel;
        logic      alumux_sel;
        logic      regfilemux_sel;
        logic      marmux_sel;
        logic      mdrmux_sel;
        lc3b_aluop aluop;
        logic      mem_read;
        logic      mem_write;
    } lc3b_ctrl_word;

    // States that hold a memory request open until mem_resp arrives.
    function automatic logic is_mem_wait(lc3b_ctrl_state s);
        return (s == s_fetch2) || (s == s_ldr1) || (s == s_str2);
    endfunction

endpackage

// File: rtl/lc3b_control_mem_wait_timer.sv
// Counts cycles spent waiting for mem_resp; expired flags the last permitted wait cycle.
// Instantiated by lc3b_control only when LC3B_CTRL_MEM_TIMEOUT_EN is defined.
module lc3b_mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == LAST_WAIT);

endmodule

// File: rtl/lc3b_control.sv
// Multicycle control FSM for the LC-3b datapath (ADD/AND/NOT/BR/LDR/STR, others run as NOP).
// Define LC3B_CTRL_MEM_TIMEOUT_EN to abort memory waits after MEM_TIMEOUT cycles with a mem_error pulse.
module lc3b_control
    import lc3b_types::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       branch_enable,
    input  logic       mem_resp,
    output logic       load_pc,
    output logic       load_ir,
    output logic       load_regfile,
    output logic       load_mar,
    output logic       load_mdr,
    output logic       load_cc,
    output logic       pcmux_sel,
    output logic       storemux_sel,
    output logic       alumux_sel,
    output logic       regfilemux_sel,
    output logic       marmux_sel,
    output logic       mdrmux_sel,
    output logic [2:0] aluop,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] mem_byte_enable,
    output logic       mem_error
);

    lc3b_ctrl_state state_reg;
    lc3b_ctrl_state state_next;
    lc3b_opcode     op;
    lc3b_ctrl_word  ctrl;
    logic           in_wait;
    logic           timeout;

    assign op      = lc3b_opcode'(opcode);
    assign in_wait = is_mem_wait(state_reg);

`ifdef LC3B_CTRL_MEM_TIMEOUT_EN
    logic wait_expired;

    lc3b_mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!in_wait),
        .inc    (in_wait && !mem_resp),
        .expired(wait_expired)
    );

    // A response arriving in the last permitted cycle still completes the access.
    assign timeout = in_wait && wait_expired && !mem_resp;
`else
    assign timeout = 1'b0;

    // MEM_TIMEOUT only matters in the timeout build; referenced here so both builds share one interface.
    if (MEM_TIMEOUT == 0) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= s_fetch1;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            s_fetch1: state_next = s_fetch2;
            s_fetch2: begin
                if (mem_resp) begin
                    state_next = s_fetch3;
                end else if (timeout) begin
                    state_next = s_fetch1;
                end
            end
            s_fetch3: state_next = s_decode;
            s_decode: begin
                case (op)
                    op_add:         state_next = s_add;
                    op_and:         state_next = s_and;
                    op_not:         state_next = s_not;
                    op_br:          state_next = s_br;
                    op_ldr, op_str: state_next = s_calc_addr;
                    default:        state_next = s_fetch1;
                endcase
            end
            s_add, s_and, s_not: state_next = s_fetch1;
            s_br:        state_next = branch_enable ? s_br_taken : s_fetch1;
            s_br_taken:  state_next = s_fetch1;
            s_calc_addr: state_next = (op == op_ldr) ? s_ldr1 : s_str1;
            s_ldr1: begin
                if (mem_resp) begin
                    state_next = s_ldr2;
                end else if (timeout) begin
                    state_next = s_fetch1;
                end
            end
            s_ldr2: state_next = s_fetch1;
            s_str1: state_next = s_str2;
            s_str2: begin
                if (mem_resp || timeout) begin
                    state_next = s_fetch1;
                end
            end
            default: state_next = s_fetch1;
        endcase
    end

    always_comb begin
        ctrl       = '0;
        ctrl.aluop = alu_add;
        case (state_reg)
            s_fetch1: begin
                ctrl.marmux_sel = 1'b1;
                ctrl.load_mar   = 1'b1;
            end
            s_fetch2, s_ldr1: begin
                ctrl.mem_read   = 1'b1;
                ctrl.mdrmux_sel = 1'b1;
                ctrl.load_mdr   = 1'b1;
            end
            s_fetch3: begin
                ctrl.load_ir = 1'b1;
                ctrl.load_pc = 1'b1;
            end
            s_add: begin
                ctrl.aluop        = alu_add;
                ctrl.load_regfile = 1'b1;
                ctrl.load_cc      = 1'b1;
            end
            s_and: begin
                ctrl.aluop        = alu_and;
                ctrl.load_regfile = 1'b1;
                ctrl.load_cc      = 1'b1;
            end
            s_not: begin
                ctrl.aluop        = alu_not;
                ctrl.load_regfile = 1'b1;
                ctrl.load_cc      = 1'b1;
            end
            s_br_taken: begin
                ctrl.pcmux_sel = 1'b1;
                ctrl.load_pc   = 1'b1;
            end
            s_calc_addr: begin
                ctrl.alumux_sel = 1'b1;
                ctrl.aluop      = alu_add;
                ctrl.load_mar   = 1'b1;
            end
            s_ldr2: begin
                ctrl.regfilemux_sel = 1'b1;
                ctrl.load_regfile   = 1'b1;
                ctrl.load_cc        = 1'b1;
            end
            s_str1: begin
                ctrl.storemux_sel = 1'b1;
                ctrl.aluop        = alu_pass;
                ctrl.load_mdr     = 1'b1;
            end
            s_str2: begin
                ctrl.mem_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset gates strobes combinationally so an in-flight request drops in the same cycle.
    assign load_pc         = ctrl.load_pc & ~rst;
    assign load_ir         = ctrl.load_ir & ~rst;
    assign load_regfile    = ctrl.load_regfile & ~rst;
    assign load_mar        = ctrl.load_mar & ~rst;
    assign load_mdr        = ctrl.load_mdr & ~rst;
    assign load_cc         = ctrl.load_cc & ~rst;
    assign mem_read        = ctrl.mem_read & ~rst;
    assign mem_write       = ctrl.mem_write & ~rst;
    assign mem_error       = timeout & ~rst;
    assign pcmux_sel       = ctrl.pcmux_sel;
    assign storemux_sel    = ctrl.storemux_sel;
    assign alumux_sel      = ctrl.alumux_sel;
    assign regfilemux_sel  = ctrl.regfilemux_sel;
    assign marmux_sel      = ctrl.marmux_sel;
    assign mdrmux_sel      = ctrl.mdrmux_sel;
    assign aluop           = ctrl.aluop;
    assign mem_byte_enable = 2'b11;

endmodule
